// File: rtl/delay_pipe_dynamic.sv
// Run-time programmable delay line (1..N cycles) with drain-before-reconfigure.
// Optional flush port enabled by defining DELAY_PIPE_DYN_FLUSH_EN.
module delay_pipe_dynamic #(
    parameter int N       = 8,
    parameter int W       = 32,
    parameter int DLY_RST = N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           in,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [$clog2(N+1)-1:0] cfg_dly,
    input  logic                   cfg_upd,
`ifdef DELAY_PIPE_DYN_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [W-1:0]           out_r,
    output logic                   out_vld_r,
    output logic [$clog2(N+1)-1:0] cfg_dly_r,
    output logic                   busy_r,
    output logic                   cfg_err_r
);

    localparam int CW = $clog2(N+1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] DLY_C  = CW'(DLY_RST);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [PW:0]   N_P    = (PW+1)'(N);
    localparam logic [PW:0]   ONE_P  = (PW+1)'(1);
    localparam logic [PW-1:0] LAST_P = PW'(N-1);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] pend;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_idx;
    logic [PW:0]   rd_sum;
    logic [N-1:0]  ring_vld;
    logic [W-1:0]  ring_data [N];
    logic          flush_now;
    logic          acc;
    logic          rd_vld;
    logic [W-1:0]  rd_data;
    logic          cfg_bad;
    logic          cfg_ok;
    logic          cfg_rej;

`ifdef DELAY_PIPE_DYN_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign in_rdy = (state == RUN);

    always_comb begin
        acc = in_vld && in_rdy && !flush_now;

        rd_sum = {1'b0, wr_ptr} + N_P - (PW+1)'(cfg_dly_r) + ONE_P;
        if (rd_sum >= N_P) begin
            rd_sum = rd_sum - N_P;
        end
        rd_idx = rd_sum[PW-1:0];

        // D=1 reads the slot being written this cycle, so bypass straight from the input
        if (cfg_dly_r == ONE_C) begin
            rd_vld  = acc;
            rd_data = in;
        end else begin
            rd_vld  = ring_vld[rd_idx];
            rd_data = ring_data[rd_idx];
        end

        cfg_bad = (cfg_dly == '0) || (cfg_dly > N_C);
        cfg_ok  = cfg_upd && !cfg_bad && !flush_now;
        cfg_rej = cfg_upd && cfg_bad && !flush_now;

        if (flush_now) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CW'(acc) - CW'(rd_vld);
        end

        wr_ptr_next = (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pend      <= DLY_C;
            cnt       <= '0;
            wr_ptr    <= '0;
            ring_vld  <= '0;
            out_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            cfg_dly_r <= DLY_C;
        end else begin
            wr_ptr    <= wr_ptr_next;
            cnt       <= cnt_next;
            busy_r    <= (cnt_next != '0);
            cfg_err_r <= cfg_rej;
            out_vld_r <= rd_vld && !flush_now;

            // Consumed slots are cleared on read so a later, longer delay never
            // re-delivers an already emitted beat.
            if (flush_now) begin
                ring_vld <= '0;
            end else begin
                ring_vld[rd_idx] <= 1'b0;
                ring_vld[wr_ptr] <= acc && (cfg_dly_r != ONE_C);
            end

            case (state)
                RUN: begin
                    if (cfg_ok) begin
                        if (cnt == '0 && !acc) begin
                            cfg_dly_r <= cfg_dly;
                        end else begin
                            pend  <= cfg_dly;
                            state <= DRAIN;
                        end
                    end
                end
                default: begin
                    if (cfg_ok) begin
                        pend <= cfg_dly;
                    end
                    if (flush_now || cnt == '0) begin
                        cfg_dly_r <= cfg_ok ? cfg_dly : pend;
                        state     <= RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            ring_data[wr_ptr] <= in;
        end
        if (rd_vld && !flush_now) begin
            out_r <= rd_data;
        end
    end

endmodule
